// File: rtl/lcd_id_pkg.sv
// Shared types, panel ID constants and the strap-code decode table.
package lcd_id_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned ID_W   = 16;
  localparam int unsigned DIV_W  = 3;

  localparam logic [ID_W-1:0] ID_4342 = 16'h4342;
  localparam logic [ID_W-1:0] ID_7084 = 16'h7084;
  localparam logic [ID_W-1:0] ID_7016 = 16'h7016;
  localparam logic [ID_W-1:0] ID_4384 = 16'h4384;
  localparam logic [ID_W-1:0] ID_1018 = 16'h1018;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [DIV_W-1:0] div;
  } panel_t;

  // Pixel-clock divisor belonging to a known panel ID; unknown IDs run undivided.
  function automatic logic [DIV_W-1:0] id_div(input logic [ID_W-1:0] id);
    case (id)
      ID_4342: return DIV_W'(4);
      ID_7084: return DIV_W'(2);
      ID_7016: return DIV_W'(1);
      ID_4384: return DIV_W'(2);
      ID_1018: return DIV_W'(1);
      default: return DIV_W'(1);
    endcase
  endfunction

  // Strap code {rgb[7],rgb[15],rgb[23]} to panel ID and divisor.
  function automatic panel_t decode_code(input logic [CODE_W-1:0] code,
                                         input logic [ID_W-1:0]   def_id);
    panel_t p;
    case (code)
      3'b000:  begin p.id = ID_4342; p.div = DIV_W'(4); end
      3'b001:  begin p.id = ID_7084; p.div = DIV_W'(2); end
      3'b010:  begin p.id = ID_7016; p.div = DIV_W'(1); end
      3'b100:  begin p.id = ID_4384; p.div = DIV_W'(2); end
      3'b101:  begin p.id = ID_1018; p.div = DIV_W'(1); end
      default: begin p.id = def_id;  p.div = id_div(def_id); end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lcd_id_dri_if.sv
// Strap inputs, re-identification request and panel ID / pixel clock outputs.
interface lcd_id_dri_if;
  logic [23:0] lcd_rgb;
  logic        redetect;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_fallback;
  logic        clk_dri;
  logic        pix_ce;

  modport master (
    output lcd_rgb, redetect,
    input  lcd_id, id_valid, id_fallback, clk_dri, pix_ce
  );

  modport slave (
    input  lcd_rgb, redetect,
    output lcd_id, id_valid, id_fallback, clk_dri, pix_ce
  );
endinterface

// File: rtl/lcd_id_dri_clk_div.sv
// Pixel clock divider: registered 50% clock for D>=2, gated sys_clk for D=1.
module lcd_clk_div
  import lcd_id_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             clk_dri_o,
  output logic             pix_ce_o
);

  logic       run_q;
  logic [1:0] cnt_q;
  logic       clk_q;
  logic       pce_q;
  logic       gate_q;
  logic       div_one_c;
  logic [1:0] last_c;
  logic [1:0] half_c;

  assign div_one_c = (divisor_i == DIV_W'(1));
  assign last_c    = 2'(divisor_i - DIV_W'(1));
  assign half_c    = 2'(divisor_i >> 1);

  // Divider counter; the first enabled cycle only arms it so a full period precedes pix_ce.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      clk_q <= 1'b0;
      pce_q <= 1'b0;
    end else if (!enable_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      clk_q <= 1'b0;
      pce_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (div_one_c) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
        pce_q <= 1'b1;
      end else if (run_q) begin
        cnt_q <= (cnt_q == last_c) ? 2'd0 : cnt_q + 2'd1;
        clk_q <= (cnt_q < half_c);
        pce_q <= (cnt_q == last_c);
      end
    end
  end

  // Gate enable moves only while sys_clk is low so the D=1 clock never glitches.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= enable_i & div_one_c;
    end
  end

  assign clk_dri_o = (sys_clk & gate_q) | clk_q;
  assign pix_ce_o  = pce_q;

endmodule

// File: rtl/lcd_id_dri.sv
// Panel identification from RGB strap pins plus pixel clock generation.
module lcd_id_dri
  import lcd_id_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter logic [15:0] DEFAULT_ID  = 16'h1018
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  lcd_id_dri_if.slave  bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC);
  localparam int unsigned STB_W = $clog2(STABLE_CNT + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [CODE_W-1:0] sync1_q;
  logic [CODE_W-1:0] sync2_q;
  state_e            state_q;
  logic [SET_W-1:0]  set_q;
  logic [STB_W-1:0]  stb_q;
  logic [CODE_W-1:0] ref_q;
  logic [TO_W-1:0]   to_q;
  logic [ID_W-1:0]   id_q;
  logic              valid_q;
  logic              fb_q;
  logic [DIV_W-1:0]  div_q;

  logic [CODE_W-1:0] code_c;
  logic              accept_c;
  logic              timeout_c;
  logic              redet_c;
  panel_t            panel_c;
  logic              valid_d;
  logic [DIV_W-1:0]  div_d;
  logic              unused_rgb_c;

  assign code_c       = {bus.lcd_rgb[7], bus.lcd_rgb[15], bus.lcd_rgb[23]};
  assign unused_rgb_c = ^{bus.lcd_rgb[23:16], bus.lcd_rgb[14:8], bus.lcd_rgb[6:0]};
  assign accept_c     = (state_q == ST_SAMPLE) && (stb_q == STB_W'(STABLE_CNT));
  assign timeout_c    = (state_q == ST_SAMPLE) && (to_q == TO_W'(TIMEOUT_CYC));
  assign redet_c      = (state_q == ST_DONE) && bus.redetect;
  assign panel_c      = decode_code(ref_q, DEFAULT_ID);

  // Two-flop synchroniser for the asynchronous strap pins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= code_c;
      sync2_q <= sync1_q;
    end
  end

  // Look-ahead of valid/divisor so the divider switches on the same edge as id_valid.
  always_comb begin
    valid_d = valid_q;
    div_d   = div_q;
    if (accept_c) begin
      valid_d = 1'b1;
      div_d   = panel_c.div;
    end else if (timeout_c) begin
      valid_d = 1'b1;
      div_d   = id_div(DEFAULT_ID);
    end else if (redet_c) begin
      valid_d = 1'b0;
    end
  end

  // Identification FSM: settle, require a run of identical codes, then hold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_SETTLE;
      set_q   <= '0;
      stb_q   <= '0;
      ref_q   <= '0;
      to_q    <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
      div_q   <= DIV_W'(1);
    end else begin
      valid_q <= valid_d;
      div_q   <= div_d;
      case (state_q)
        ST_SETTLE: begin
          if (set_q == SET_W'(SETTLE_CYC - 1)) begin
            state_q <= ST_SAMPLE;
            set_q   <= '0;
            stb_q   <= '0;
            to_q    <= '0;
          end else begin
            set_q <= set_q + SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          to_q <= to_q + TO_W'(1);
          if (accept_c) begin
            state_q <= ST_DONE;
            id_q    <= panel_c.id;
            fb_q    <= 1'b0;
          end else if (timeout_c) begin
            state_q <= ST_DONE;
            id_q    <= DEFAULT_ID;
            fb_q    <= 1'b1;
          end else if ((stb_q == '0) || (sync2_q != ref_q)) begin
            ref_q <= sync2_q;
            stb_q <= STB_W'(1);
          end else begin
            stb_q <= stb_q + STB_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.redetect) begin
            state_q <= ST_SETTLE;
            set_q   <= '0;
            fb_q    <= 1'b0;
          end
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

  lcd_clk_div u_clk_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable_i  (valid_d),
    .divisor_i (div_d),
    .clk_dri_o (bus.clk_dri),
    .pix_ce_o  (bus.pix_ce)
  );

  assign bus.lcd_id      = id_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_fallback = fb_q;

endmodule

// File: tb/tb_lcd_id_dri.sv
// Directed bench for lcd_id_dri: strap decode table, timeout, glitch, redetect, reset.
module tb_lcd_id_dri;
  import lcd_id_pkg::*;

  typedef struct {
    logic [2:0]  code;
    int          mode;      // 0 constant, 1 toggle 001/010, 2 one-cycle 011 glitch, 3 redetect in SETTLE
    logic [15:0] exp_id;
    logic        exp_fb;
    int          exp_edge;
    int          exp_div;
  } vec_t;

  logic sys_clk;
  logic sys_rst_n;
  int   n_vec;
  int   n_err;

  lcd_id_dri_if bus_if ();

  lcd_id_dri #(
    .SETTLE_CYC  (8),
    .STABLE_CNT  (4),
    .TIMEOUT_CYC (64),
    .DEFAULT_ID  (16'h1018)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_if)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {11'd0, bus_if.lcd_id, bus_if.id_valid, bus_if.id_fallback,
               bus_if.clk_dri, bus_if.pix_ce}, 32'd0);
  endtask

  task automatic set_code(input logic [2:0] c);
    bus_if.lcd_rgb     = '0;
    bus_if.lcd_rgb[7]  = c[2];
    bus_if.lcd_rgb[15] = c[1];
    bus_if.lcd_rgb[23] = c[0];
  endtask

  // Reset with the given straps, released at a falling edge so the next rise is edge 1.
  task automatic do_reset(input logic [2:0] c);
    sys_rst_n       = 1'b0;
    bus_if.redetect = 1'b0;
    set_code(c);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Count rising edges until id_valid, applying the per-mode strap/redetect stimulus.
  task automatic wait_valid(input int mode, input logic [2:0] c,
                            output int edge_n, output logic saw_def);
    edge_n  = 0;
    saw_def = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge sys_clk);
      #1;
      if (bus_if.id_valid) begin
        edge_n = i;
        break;
      end
      if (bus_if.lcd_id == 16'h1018) saw_def = 1'b1;
      if (mode == 1) set_code((i % 2) ? 3'b010 : 3'b001);
      if (mode == 2 && i == 8) set_code(3'b011);
      if (mode == 2 && i == 9) set_code(c);
      if (mode == 3 && i == 3) bus_if.redetect = 1'b1;
      if (mode == 3 && i == 4) bus_if.redetect = 1'b0;
    end
  endtask

  // Starting on the id_valid edge, check eight periods of clk_dri/pix_ce.
  task automatic check_div(input int d);
    int   bad;
    logic exp_clk;
    logic exp_pce;
    bad = 0;
    if (bus_if.pix_ce !== (d == 1)) bad++;
    if (bus_if.clk_dri !== (d == 1)) bad++;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk);
      #1;
      exp_pce = (d == 1) ? 1'b1 : ((k % d) == 0);
      exp_clk = (d == 1) ? 1'b1 : (((k - 1) % d) < (d / 2));
      if (bus_if.pix_ce !== exp_pce) bad++;
      if (bus_if.clk_dri !== exp_clk) bad++;
      @(negedge sys_clk);
      #1;
      if (d == 1 && bus_if.clk_dri !== 1'b0) bad++;
    end
    chk($sformatf("divider_d%0d", d), bad, 0);
  endtask

  initial begin
    vec_t vecs[10];
    int   e;
    logic saw;

    n_vec = 0;
    n_err = 0;
    vecs[0] = '{3'b000, 0, 16'h4342, 1'b0, 13, 4};
    vecs[1] = '{3'b001, 0, 16'h7084, 1'b0, 13, 2};
    vecs[2] = '{3'b010, 0, 16'h7016, 1'b0, 13, 1};
    vecs[3] = '{3'b100, 0, 16'h4384, 1'b0, 13, 2};
    vecs[4] = '{3'b101, 0, 16'h1018, 1'b0, 13, 1};
    vecs[5] = '{3'b011, 0, 16'h1018, 1'b0, 13, 1};
    vecs[6] = '{3'b110, 0, 16'h1018, 1'b0, 13, 1};
    vecs[7] = '{3'b111, 0, 16'h1018, 1'b0, 13, 1};
    vecs[8] = '{3'b001, 1, 16'h1018, 1'b1, 73, 1};
    vecs[9] = '{3'b001, 2, 16'h7084, 1'b0, 16, 2};

    sys_rst_n       = 1'b1;
    bus_if.redetect = 1'b0;
    set_code(3'b000);
    #1 sys_rst_n = 1'b0;
    #2;
    chk_zero("reset_values");

    foreach (vecs[n]) begin
      do_reset(vecs[n].code);
      wait_valid(vecs[n].mode, vecs[n].code, e, saw);
      chk($sformatf("v%0d_valid_edge", n), e, vecs[n].exp_edge);
      chk($sformatf("v%0d_lcd_id", n), {16'd0, bus_if.lcd_id}, {16'd0, vecs[n].exp_id});
      chk($sformatf("v%0d_fallback", n), {31'd0, bus_if.id_fallback}, {31'd0, vecs[n].exp_fb});
      if (vecs[n].mode == 2) chk("glitch_no_default", {31'd0, saw}, 32'd0);
      check_div(vecs[n].exp_div);
    end

    // Redetect from DONE (7084, div2) with straps moved to 100.
    @(posedge sys_clk);
    #1 set_code(3'b100);
    repeat (3) @(posedge sys_clk);
    #1 bus_if.redetect = 1'b1;
    @(posedge sys_clk);
    #1 bus_if.redetect = 1'b0;
    chk("redet_outputs_low", {29'd0, bus_if.id_valid, bus_if.clk_dri, bus_if.pix_ce}, 32'd0);
    chk("redet_id_held", {16'd0, bus_if.lcd_id}, 32'h7084);
    chk("redet_fallback", {31'd0, bus_if.id_fallback}, 32'd0);
    wait_valid(3, 3'b100, e, saw);
    chk("redet_valid_edge", e, 13);
    chk("redet_lcd_id", {16'd0, bus_if.lcd_id}, 32'h4384);
    check_div(2);

    // Asynchronous reset in DONE, in SAMPLE, then full re-identification.
    do_reset(3'b000);
    wait_valid(0, 3'b000, e, saw);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1 chk_zero("reset_in_done");
    do_reset(3'b000);
    repeat (10) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1 chk_zero("reset_in_sample");
    do_reset(3'b000);
    wait_valid(0, 3'b000, e, saw);
    chk("reident_valid_edge", e, 13);
    chk("reident_lcd_id", {16'd0, bus_if.lcd_id}, 32'h4342);

    // Reset while the undivided clock is high must force clk_dri low at once.
    do_reset(3'b101);
    wait_valid(0, 3'b101, e, saw);
    @(posedge sys_clk);
    #1 chk("d1_clk_high", {31'd0, bus_if.clk_dri}, 32'd1);
    sys_rst_n = 1'b0;
    #1 chk_zero("reset_d1_clk");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
